// File: rtl/mips_cpu_ram_waitstate.sv
// mips_cpu_ram_waitstate
// Word-organised 32-bit RAM with byte-lane enables and a programmable number
// of wait states inserted in front of every read or write.
//
// Handshake: a request is present when exactly one of read/write is high.
// waitrequest is combinational. The access is accepted on the rising edge
// where the request is present and waitrequest is low. address, writedata and
// byteenable are used only at that edge. readdata is registered and is
// valid from the cycle after an accepted read. It is held until the next
// accepted read. Read and write together form a no-op that is accepted at once.
//
// Optional feature: define MIPS_CPU_RAM_ALIGN_CHECK_EN to flag accesses with
// address[1:0] != 0. Such accesses are still accepted, but they write nothing
// and read zero. fault pulses for one cycle after acceptance. Without the
// macro, the low address bits are ignored and fault is tied low.
module mips_cpu_ram_waitstate #(
  parameter int    ADDR_WIDTH    = 12,
  parameter int    WAIT_CYCLES   = 2,
  parameter string RAM_INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        fault,
  output logic        dbg_state,
  output logic [3:0]  dbg_count
);

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LIM = 4'(WAIT_CYCLES);

  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic                    req;
  logic                    accept;
  logic                    misaligned;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [31:0]             lane_mask;
  logic [31:0]             mem [DEPTH];
  logic                    unused_addr;

  // Memory image starts all-zero. Reset never touches it.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  end

  assign req         = read ^ write;
  assign idx         = address[ADDR_WIDTH+1:2];
  assign lane_mask   = {{8{byteenable[3]}}, {8{byteenable[2]}},
                        {8{byteenable[1]}}, {8{byteenable[0]}}};
  assign unused_addr = ^{address[31:ADDR_WIDTH+2], address[1:0]};
  assign dbg_state   = state_q;
  assign dbg_count   = cnt_q;

  // State register: FSM state and wait counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count stall cycles while the request is held, and clear on accept or drop.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req && waitrequest) begin
          state_d = STALL;
          cnt_d   = cnt_q + 4'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      STALL: begin
        if (!req || accept) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          state_d = STALL;
          cnt_d   = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs: stall the master until enough wait states have elapsed. Always stall in reset.
  always_comb begin
    waitrequest = 1'b1;
    accept      = 1'b0;
    if (!reset) begin
      waitrequest = req && (cnt_q < WAIT_LIM);
      accept      = req && !waitrequest;
    end
  end

`ifdef MIPS_CPU_RAM_ALIGN_CHECK_EN
  assign misaligned = (address[1:0] != 2'b00);

  // One-cycle fault pulse after a misaligned access is accepted.
  always_ff @(posedge clk) begin
    if (reset) fault <= 1'b0;
    else       fault <= accept && misaligned;
  end
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  // Memory write: update only the enabled lanes of an accepted, aligned write.
  always_ff @(posedge clk) begin
    if (accept && write && !misaligned) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable[b]) mem[idx][8*b +: 8] <= writedata[8*b +: 8];
      end
    end
  end

  // Read register: capture enabled lanes on an accepted read. Otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
    end else if (accept && read) begin
      readdata <= misaligned ? 32'h0 : (mem[idx] & lane_mask);
    end
  end

endmodule

// File: tb/tb_mips_cpu_ram_waitstate.sv
// Directed bench for mips_cpu_ram_waitstate (default ADDR_WIDTH=12, WAIT_CYCLES=2).
// Expectations follow MIPS_CPU_RAM_ALIGN_CHECK_EN the same way the design does.
module tb_mips_cpu_ram_waitstate;

  localparam int WAIT = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        fault;
  logic        dbg_state;
  logic [3:0]  dbg_count;

  int vectors     = 0;
  int miscompares = 0;

  mips_cpu_ram_waitstate #(
    .ADDR_WIDTH   (12),
    .WAIT_CYCLES  (WAIT),
    .RAM_INIT_FILE("")
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .write      (write),
    .read       (read),
    .writedata  (writedata),
    .byteenable (byteenable),
    .readdata   (readdata),
    .waitrequest(waitrequest),
    .fault      (fault),
    .dbg_state  (dbg_state),
    .dbg_count  (dbg_count)
  );

  // Clock: 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drive one request. Check waitrequest on every cycle until acceptance.
  // Then check readdata and fault in the cycle after acceptance.
  // Finally check that fault has dropped one cycle later.
  task automatic access(input string tag, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input int stalls,
                        input logic [31:0] exp_rd, input logic exp_fault);
    @(negedge clk);
    address = a; writedata = d; byteenable = be; read = rd; write = wr;
    for (int c = 0; c <= stalls; c++) begin
      #1;
      check({tag, "/wait"}, {31'b0, waitrequest}, {31'b0, (c < stalls)});
      @(posedge clk);
    end
    #1;
    read = 1'b0; write = 1'b0;
    check({tag, "/rdata"}, readdata, exp_rd);
    check({tag, "/fault"}, {31'b0, fault}, {31'b0, exp_fault});
    @(posedge clk);
    #1;
    check({tag, "/fault_drop"}, {31'b0, fault}, 32'h0);
  endtask

  logic        align_en;
  logic [31:0] exp_w10;

  initial begin
`ifdef MIPS_CPU_RAM_ALIGN_CHECK_EN
    align_en = 1'b1;
`else
    align_en = 1'b0;
`endif
    reset = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst/rdata", readdata, 32'h0);
    check("rst/fault", {31'b0, fault}, 32'h0);
    check("rst/wait", {31'b0, waitrequest}, 32'h1);
    check("rst/count", {28'b0, dbg_count}, 32'h0);
    check("rst/state", {31'b0, dbg_state}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("idle/wait", {31'b0, waitrequest}, 32'h0);

    // Full-word write and read back
    access("wr10",    1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, WAIT, 32'h0,        1'b0);
    access("rd10",    1'b1, 1'b0, 32'h10, 32'h0,        4'b1111, WAIT, 32'hDEADBEEF, 1'b0);
    // Lane-enabled write, then full and partial reads
    access("wr10_b0", 1'b0, 1'b1, 32'h10, 32'h000000AA, 4'b0001, WAIT, 32'hDEADBEEF, 1'b0);
    access("rd10_f",  1'b1, 1'b0, 32'h10, 32'h0,        4'b1111, WAIT, 32'hDEADBEAA, 1'b0);
    access("rd10_c",  1'b1, 1'b0, 32'h10, 32'h0,        4'b1100, WAIT, 32'hDEAD0000, 1'b0);
    // Address wrap modulo 4096 words
    access("wr4000",  1'b0, 1'b1, 32'h4000, 32'h12345678, 4'b1111, WAIT, 32'hDEAD0000, 1'b0);
    access("rd0",     1'b1, 1'b0, 32'h0,    32'h0,        4'b1111, WAIT, 32'h12345678, 1'b0);
    // read+write together: an immediate no-op with readdata held and memory untouched
    access("noop",    1'b1, 1'b1, 32'h10, 32'h0,        4'b1111, 0,    32'h12345678, 1'b0);
    access("rd10_n",  1'b1, 1'b0, 32'h10, 32'h0,        4'b1111, WAIT, 32'hDEADBEAA, 1'b0);
    // Top lane only
    access("wr10_b3", 1'b0, 1'b1, 32'h10, 32'h77665544, 4'b1000, WAIT, 32'hDEADBEAA, 1'b0);
    access("rd10_b3", 1'b1, 1'b0, 32'h10, 32'h0,        4'b1111, WAIT, 32'h77ADBEAA, 1'b0);

    // Read dropped after one stall cycle: no access occurs
    @(negedge clk);
    address = 32'h10; byteenable = 4'b1111; read = 1'b1;
    #1;
    check("drop/wait", {31'b0, waitrequest}, 32'h1);
    @(posedge clk); #1;
    check("drop/count1", {28'b0, dbg_count}, 32'h1);
    check("drop/stall",  {31'b0, dbg_state}, 32'h1);
    @(negedge clk);
    read = 1'b0;
    #1;
    check("drop/wait_lo", {31'b0, waitrequest}, 32'h0);
    @(posedge clk); #1;
    check("drop/count0", {28'b0, dbg_count}, 32'h0);
    check("drop/idle",   {31'b0, dbg_state}, 32'h0);
    check("drop/rdata",  readdata, 32'h77ADBEAA);

    // Reset during the stall of a write to 0x20 aborts the write
    @(negedge clk);
    address = 32'h20; writedata = 32'hCAFEF00D; byteenable = 4'b1111; write = 1'b1;
    @(posedge clk); #1;
    check("rstall/count1", {28'b0, dbg_count}, 32'h1);
    check("rstall/stall",  {31'b0, dbg_state}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstall/wait", {31'b0, waitrequest}, 32'h1);
    @(posedge clk); #1;
    check("rstall/rdata", readdata, 32'h0);
    check("rstall/count", {28'b0, dbg_count}, 32'h0);
    check("rstall/idle",  {31'b0, dbg_state}, 32'h0);
    @(negedge clk);
    reset = 1'b0; write = 1'b0;
    access("rd20",    1'b1, 1'b0, 32'h20, 32'h0, 4'b1111, WAIT, 32'h0,        1'b0);
    access("rd10_kp", 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, WAIT, 32'h77ADBEAA, 1'b0);

    // Misaligned write to 0x13
    access("wr13",    1'b0, 1'b1, 32'h13, 32'hA5A5A5A5, 4'b1111, WAIT, 32'h77ADBEAA, align_en);
    exp_w10 = align_en ? 32'h77ADBEAA : 32'hA5A5A5A5;
    access("rd10_al", 1'b1, 1'b0, 32'h10, 32'h0, 4'b1111, WAIT, exp_w10, 1'b0);
    // Misaligned read: zero when the alignment check is enabled, else the whole word
    access("rd11",    1'b1, 1'b0, 32'h11, 32'h0, 4'b1111, WAIT,
           align_en ? 32'h0 : exp_w10, align_en);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
